// File: rtl/opb_register_simulink2ppc_sc_pkg.sv
// Shared definitions for the simulink2ppc return-path OPB register slave:
// register word indices, STATUS bit layout and the bus-side FSM state type.
package opb_register_simulink2ppc_sc_pkg;

  localparam int unsigned DATA_WORD   = 0;
  localparam int unsigned STATUS_WORD = 1;

  localparam int unsigned ST_NEW_DATA_BIT = 0;
  localparam int unsigned ST_OVERRUN_BIT  = 1;
  localparam int unsigned ST_COUNT_LSB    = 16;
  localparam int unsigned ST_COUNT_W      = 16;

  typedef enum logic {
    S_IDLE,
    S_ACK
  } fsm_state_e;

  typedef enum logic [1:0] {
    SEL_DATA,
    SEL_STATUS,
    SEL_NONE
  } word_sel_e;

  function automatic logic [31:0] pack_status(input logic [ST_COUNT_W-1:0] count,
                                              input logic overrun,
                                              input logic new_data);
    logic [31:0] v;
    v = '0;
    v[ST_COUNT_LSB +: ST_COUNT_W] = count;
    v[ST_OVERRUN_BIT]             = overrun;
    v[ST_NEW_DATA_BIT]            = new_data;
    return v;
  endfunction

endpackage

// File: rtl/opb_register_simulink2ppc_sc_ack.sv
// Address decode plus IDLE/ACK sequencing for a single-beat OPB slave.
// Strobes are combinational and mark the IDLE->ACK edge on which side effects commit.
module opb_slave_ack_fsm
  import opb_register_simulink2ppc_sc_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR = 32'h0106_0400,
  parameter logic [31:0] C_HIGHADDR = 32'h0106_04FF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] i_abus,
  input  logic        i_rnw,
  input  logic        i_select,
  output logic        o_ack,
  output logic        o_rd_strobe,
  output logic        o_wr_strobe,
  output word_sel_e   o_word_sel
);

  localparam logic [31:0] C_MASK = C_HIGHADDR - C_BASEADDR;

  fsm_state_e  r_state;
  fsm_state_e  w_next;
  logic        w_hit;
  logic [31:0] w_word_idx;

  assign w_hit      = (i_abus & ~C_MASK) == C_BASEADDR;
  // Byte-lane bits are dropped: any byte address inside a word selects that word.
  assign w_word_idx = (i_abus & C_MASK) >> 2;

  always_comb begin
    o_word_sel = SEL_NONE;
    if (w_word_idx == 32'(DATA_WORD))        o_word_sel = SEL_DATA;
    else if (w_word_idx == 32'(STATUS_WORD)) o_word_sel = SEL_STATUS;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state elements use non-blocking assignment so every flop samples pre-edge values.
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    // NOTE: every output gets a default first, so no path leaves a latch behind.
    w_next      = r_state;
    o_ack       = 1'b0;
    o_rd_strobe = 1'b0;
    o_wr_strobe = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_select && w_hit) begin
          w_next      = S_ACK;
          o_rd_strobe = i_rnw;
          o_wr_strobe = ~i_rnw;
        end
      end
      S_ACK: begin
        o_ack  = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

endmodule

// File: rtl/opb_register_simulink2ppc_sc.sv
// OPB slave returning a fabric-captured snapshot word (DATA) and a sticky STATUS
// word {count, overrun, new_data} to the PowerPC, all on the single OPB clock.
module opb_register_simulink2ppc_sc
  import opb_register_simulink2ppc_sc_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR   = 32'h0106_0400,
  parameter logic [31:0] C_HIGHADDR   = 32'h0106_04FF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter string       C_FAMILY     = "virtex5"
) (
  input  logic                    OPB_Clk,
  input  logic                    OPB_Rst_n,
  input  logic [0:C_OPB_AWIDTH-1] OPB_ABus,
  input  logic [0:3]              OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1] OPB_DBus,
  input  logic                    OPB_RNW,
  input  logic                    OPB_select,
  input  logic                    OPB_seqAddr,
  output logic [0:C_OPB_DWIDTH-1] Sl_DBus,
  output logic                    Sl_xferAck,
  output logic                    Sl_errAck,
  output logic                    Sl_retry,
  output logic                    Sl_toutSup,
  input  logic [31:0]             user_data_in,
  input  logic                    user_data_valid
);

  logic                    w_rd_strobe;
  logic                    w_wr_strobe;
  word_sel_e               w_word_sel;
  logic                    w_clr_data;
  logic                    w_clr_count;
  logic [31:0]             w_rd_value;
  logic                    w_unused;

  logic [31:0]             r_data;
  logic [ST_COUNT_W-1:0]   r_count;
  logic                    r_new_data;
  logic                    r_overrun;
  logic [0:C_OPB_DWIDTH-1] r_sl_dbus;

  opb_slave_ack_fsm #(
    .C_BASEADDR (C_BASEADDR),
    .C_HIGHADDR (C_HIGHADDR)
  ) u_ack_fsm (
    .clk         (OPB_Clk),
    .rst_n       (OPB_Rst_n),
    .i_abus      (OPB_ABus),
    .i_rnw       (OPB_RNW),
    .i_select    (OPB_select),
    .o_ack       (Sl_xferAck),
    .o_rd_strobe (w_rd_strobe),
    .o_wr_strobe (w_wr_strobe),
    .o_word_sel  (w_word_sel)
  );

  assign w_clr_data  = w_rd_strobe && (w_word_sel == SEL_DATA);
  assign w_clr_count = w_wr_strobe && (w_word_sel == SEL_STATUS);

  always_comb begin
    w_rd_value = '0;
    case (w_word_sel)
      SEL_DATA:   w_rd_value = r_data;
      SEL_STATUS: w_rd_value = pack_status(r_count, r_overrun, r_new_data);
      default:    w_rd_value = '0;
    endcase
  end

  // Capture set wins over a same-cycle read clear; overrun only arms when the
  // previous word is still unread after this edge.
  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    // NOTE: every register here is a plain flop with a defined reset value; there is no RAM to leave unreset.
    if (!OPB_Rst_n) begin
      r_data     <= '0;
      r_count    <= '0;
      r_new_data <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      if (user_data_valid) r_data <= user_data_in;

      if (user_data_valid)  r_count <= w_clr_count ? ST_COUNT_W'(1) : r_count + 1'b1;
      else if (w_clr_count) r_count <= '0;

      if (user_data_valid) r_new_data <= 1'b1;
      else if (w_clr_data) r_new_data <= 1'b0;

      if (user_data_valid && r_new_data && !w_clr_data) r_overrun <= 1'b1;
      else if (w_clr_data)                              r_overrun <= 1'b0;
    end
  end

  // A [31:0] value assigned to a [0:31] bus lands MSB-first, which is the OPB bit order.
  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n)       r_sl_dbus <= '0;
    else if (w_rd_strobe) r_sl_dbus <= C_OPB_DWIDTH'(w_rd_value);
    else                  r_sl_dbus <= '0;
  end

  assign Sl_DBus    = r_sl_dbus;
  assign Sl_errAck  = 1'b0;
  assign Sl_retry   = 1'b0;
  assign Sl_toutSup = 1'b0;

  assign w_unused = ^{OPB_BE, OPB_DBus, OPB_seqAddr, (C_FAMILY == "virtex5")};

endmodule

// File: tb/tb_opb_register_simulink2ppc_sc.sv
// Self-checking bench: table of OPB transfers and capture pulses plus hand-written
// corner sequences; expected read data flows through a scoreboard queue.
module tb_opb_register_simulink2ppc_sc;

  localparam logic [31:0] BASE = 32'h0106_0400;

  logic        OPB_Clk = 1'b0;
  logic        OPB_Rst_n;
  logic [0:31] OPB_ABus;
  logic [0:3]  OPB_BE;
  logic [0:31] OPB_DBus;
  logic        OPB_RNW;
  logic        OPB_select;
  logic        OPB_seqAddr;
  logic [0:31] Sl_DBus;
  logic        Sl_xferAck;
  logic        Sl_errAck;
  logic        Sl_retry;
  logic        Sl_toutSup;
  logic [31:0] user_data_in;
  logic        user_data_valid;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] exp_q[$];

  typedef struct {
    logic        is_pulse;
    logic        rnw;
    logic [31:0] off;
    logic [31:0] data;
    logic        cap;
    logic [31:0] capd;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t tbl[$];

  opb_register_simulink2ppc_sc dut (
    .OPB_Clk         (OPB_Clk),
    .OPB_Rst_n       (OPB_Rst_n),
    .OPB_ABus        (OPB_ABus),
    .OPB_BE          (OPB_BE),
    .OPB_DBus        (OPB_DBus),
    .OPB_RNW         (OPB_RNW),
    .OPB_select      (OPB_select),
    .OPB_seqAddr     (OPB_seqAddr),
    .Sl_DBus         (Sl_DBus),
    .Sl_xferAck      (Sl_xferAck),
    .Sl_errAck       (Sl_errAck),
    .Sl_retry        (Sl_retry),
    .Sl_toutSup      (Sl_toutSup),
    .user_data_in    (user_data_in),
    .user_data_valid (user_data_valid)
  );

  always #5 OPB_Clk = ~OPB_Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic pulse(input logic [31:0] d);
    @(negedge OPB_Clk);
    user_data_valid = 1'b1;
    user_data_in    = d;
    @(negedge OPB_Clk);
    user_data_valid = 1'b0;
  endtask

  // One transfer: select at a negedge, ack must follow the next posedge and last one cycle.
  task automatic xfer(input logic rnw, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic cap, input logic [31:0] capd,
                      input logic [31:0] exp, input string name);
    logic [31:0] e;
    logic [31:0] act;
    exp_q.push_back(rnw ? exp : 32'h0);
    @(negedge OPB_Clk);
    OPB_select = 1'b1;
    OPB_RNW    = rnw;
    OPB_ABus   = addr;
    OPB_DBus   = wdata;
    if (cap) begin
      user_data_valid = 1'b1;
      user_data_in    = capd;
    end
    #1 check({name, " ack_early"}, {31'b0, Sl_xferAck}, 32'h0);
    @(posedge OPB_Clk);
    #1;
    OPB_select      = 1'b0;
    user_data_valid = 1'b0;
    e = exp_q.pop_front();
    if (Sl_xferAck !== 1'b1) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s ack: got %b expected 1 (expected data %08h never produced)", name, Sl_xferAck, e);
    end else begin
      act = Sl_DBus;
      check({name, " data"}, act, e);
    end
    @(posedge OPB_Clk);
    #1;
    check({name, " ack_width"}, {31'b0, Sl_xferAck}, 32'h0);
    act = Sl_DBus;
    check({name, " dbus_idle"}, act, 32'h0);
  endtask

  function automatic void add_xfer(input logic rnw, input logic [31:0] off, input logic [31:0] wd,
                                   input logic cap, input logic [31:0] capd,
                                   input logic [31:0] exp, input string name);
    vec_t v;
    v.is_pulse = 1'b0; v.rnw = rnw; v.off = off; v.data = wd;
    v.cap = cap; v.capd = capd; v.exp = exp; v.name = name;
    tbl.push_back(v);
  endfunction

  function automatic void add_pulse(input logic [31:0] d);
    vec_t v;
    v.is_pulse = 1'b1; v.rnw = 1'b0; v.off = '0; v.data = d;
    v.cap = 1'b0; v.capd = '0; v.exp = '0; v.name = "pulse";
    tbl.push_back(v);
  endfunction

  initial begin
    logic [31:0] act;
    int          acks;

    OPB_Rst_n = 1'b0; OPB_ABus = '0; OPB_BE = '0; OPB_DBus = '0; OPB_RNW = 1'b0;
    OPB_select = 1'b0; OPB_seqAddr = 1'b0; user_data_in = '0; user_data_valid = 1'b0;

    // rnw, offset, wdata, cap, capd, expected, name
    add_xfer(1, 32'h0, 0, 0, 0, 32'h0000_0000, "rst DATA");
    add_xfer(1, 32'h4, 0, 0, 0, 32'h0000_0000, "rst STATUS");
    add_pulse(32'hDEAD_BEEF);
    add_xfer(1, 32'h4, 0, 0, 0, 32'h0001_0001, "one STATUS");
    add_xfer(1, 32'h0, 0, 0, 0, 32'hDEAD_BEEF, "one DATA");
    add_xfer(1, 32'h4, 0, 0, 0, 32'h0001_0000, "one STATUS after");
    add_xfer(0, 32'h4, 32'h0, 0, 0, 32'h0, "clr count");
    add_pulse(32'h1);
    add_pulse(32'h2);
    add_xfer(1, 32'h4, 0, 0, 0, 32'h0002_0003, "two STATUS");
    add_xfer(1, 32'h0, 0, 0, 0, 32'h0000_0002, "two DATA");
    add_xfer(1, 32'h4, 0, 0, 0, 32'h0002_0000, "two STATUS after");
    add_pulse(32'h10);
    add_pulse(32'h11);
    add_xfer(1, 32'h0, 0, 1, 32'h22, 32'h0000_0011, "simul DATA read");
    add_xfer(1, 32'h4, 0, 0, 0, 32'h0005_0001, "simul STATUS");
    add_xfer(1, 32'h0, 0, 0, 0, 32'h0000_0022, "simul DATA new");
    add_xfer(0, 32'h4, 32'h0, 1, 32'h33, 32'h0, "simul STATUS wr");
    add_xfer(1, 32'h4, 0, 1, 32'h44, 32'h0001_0001, "simul STATUS rd");
    add_xfer(1, 32'h4, 0, 0, 0, 32'h0002_0003, "post simul STATUS");
    add_xfer(1, 32'h0, 0, 0, 0, 32'h0000_0044, "post simul DATA");
    add_xfer(1, 32'h8, 0, 0, 0, 32'h0, "other offset rd");
    add_xfer(0, 32'h8, 32'hFFFF_FFFF, 0, 0, 32'h0, "other offset wr");
    add_xfer(0, 32'h4, 32'h0, 0, 0, 32'h0, "clr before wrap");

    repeat (3) @(posedge OPB_Clk);
    #1;
    check("reset ack", {31'b0, Sl_xferAck}, 32'h0);
    act = Sl_DBus;
    check("reset dbus", act, 32'h0);
    @(negedge OPB_Clk);
    OPB_Rst_n = 1'b1;

    foreach (tbl[i]) begin
      if (tbl[i].is_pulse) pulse(tbl[i].data);
      else xfer(tbl[i].rnw, BASE + tbl[i].off, tbl[i].data, tbl[i].cap, tbl[i].capd,
                tbl[i].exp, tbl[i].name);
    end

    // Count wraps: 65537 captures leave count at 1.
    for (int i = 0; i < 65537; i++) begin
      @(negedge OPB_Clk);
      user_data_valid = 1'b1;
      user_data_in    = 32'(i);
    end
    @(negedge OPB_Clk);
    user_data_valid = 1'b0;
    xfer(1, BASE + 32'h4, 0, 0, 0, 32'h0001_0003, "wrap STATUS");
    xfer(0, BASE + 32'h4, 32'hFFFF_FFFF, 0, 0, 32'h0, "wr STATUS ones");
    xfer(1, BASE + 32'h4, 0, 0, 0, 32'h0000_0003, "wrap STATUS cleared");
    xfer(0, BASE + 32'h0, 32'h1234_5678, 0, 0, 32'h0, "wr DATA");
    xfer(1, BASE + 32'h0, 0, 0, 0, 32'h0001_0000, "DATA unchanged");

    // Out-of-window requests get no ack and leave the bus at zero.
    @(negedge OPB_Clk);
    OPB_select = 1'b1; OPB_RNW = 1'b1; OPB_ABus = BASE + 32'h100;
    acks = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge OPB_Clk); #1;
      if (Sl_xferAck === 1'b1 || Sl_DBus !== 32'h0) acks++;
    end
    OPB_ABus = 32'h0000_0000;
    for (int i = 0; i < 3; i++) begin
      @(posedge OPB_Clk); #1;
      if (Sl_xferAck === 1'b1 || Sl_DBus !== 32'h0) acks++;
    end
    check("out of window", 32'(acks), 32'h0);

    // Held select is a burst: one ack every two cycles, each returning DATA.
    OPB_ABus = BASE;
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge OPB_Clk); #1;
      if (Sl_xferAck === 1'b1) acks++;
      check($sformatf("burst ack c%0d", i), {31'b0, Sl_xferAck}, (i % 2 == 0) ? 32'h1 : 32'h0);
    end
    OPB_select = 1'b0;
    check("burst ack count", 32'(acks), 32'h2);

    // Reset during ACK drops the ack at once and clears all registers.
    pulse(32'h77);
    @(negedge OPB_Clk);
    OPB_select = 1'b1; OPB_RNW = 1'b1; OPB_ABus = BASE;
    @(posedge OPB_Clk); #1;
    OPB_select = 1'b0;
    check("pre-reset ack", {31'b0, Sl_xferAck}, 32'h1);
    #1 OPB_Rst_n = 1'b0;
    #1;
    check("async reset ack", {31'b0, Sl_xferAck}, 32'h0);
    act = Sl_DBus;
    check("async reset dbus", act, 32'h0);
    @(negedge OPB_Clk);
    OPB_Rst_n = 1'b1;
    xfer(1, BASE + 32'h0, 0, 0, 0, 32'h0, "post-reset DATA");
    xfer(1, BASE + 32'h4, 0, 0, 0, 32'h0, "post-reset STATUS");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
